// File: rtl/syn_global_pkg.sv
// Shared types and constants for the local-bus fabric.
package syn_global_pkg;

  typedef enum logic {IDLE, WAIT} lb_fabric_fsm_t;

  localparam logic [31:0] LB_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/syn_lb_fabric_if.sv
// Master-side local-bus bundle: request strobes/address/data and the registered response.
interface syn_lb_fabric_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              wr_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;

  modport master (
    output rd_en, wr_en, addr, wr_data,
    input  rd_valid, wr_valid, rd_data, err
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data,
    output rd_valid, wr_valid, rd_data, err
  );
endinterface

// File: rtl/syn_lb_rst_stretch.sv
// Restartable pulse stretcher: a trigger (re)loads the down-counter; output is high while non-zero.
module syn_lb_rst_stretch #(
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);
  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (trig) begin
      cnt_q <= CNT_W'(PULSE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign pulse = (cnt_q != '0);
endmodule

// File: rtl/syn_lb_fabric.sv
// Local-bus fabric: decodes one master onto NUM_SLAVES slaves by block code, one outstanding op.
// Optional WAIT timeout enabled by defining LB_FABRIC_TIMEOUT_EN.
module syn_lb_fabric
  import syn_global_pkg::*;
#(
  parameter int unsigned             NUM_SLAVES       = 4,
  parameter int unsigned             DATA_W           = 32,
  parameter int unsigned             ADDR_W           = 12,
  parameter int unsigned             SLV_ADDR_W       = 8,
  parameter int unsigned             TIMEOUT_CYCLES   = 16,
  parameter logic [SLV_ADDR_W-1:0]   SLV_RST_ADDR     = {SLV_ADDR_W{1'b1}},
  parameter int unsigned             RST_PULSE_CYCLES = 4
) (
  input  logic                         clk_ir,
  input  logic                         rst_ir,
  syn_lb_fabric_if.slave               lb,
  output logic [NUM_SLAVES-1:0]        slv_rd_en,
  output logic [NUM_SLAVES-1:0]        slv_wr_en,
  output logic [SLV_ADDR_W-1:0]        slv_addr,
  output logic [DATA_W-1:0]            slv_wr_data,
  input  logic [NUM_SLAVES-1:0]        slv_rd_valid,
  input  logic [NUM_SLAVES-1:0]        slv_wr_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data,
  output logic [NUM_SLAVES-1:0]        slv_rst,
  output logic [7:0]                   err_cnt
);
  localparam int unsigned CODE_W = ADDR_W - SLV_ADDR_W;
  localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES > (1 << CODE_W)) begin : g_bad_num_slaves
    $error("NUM_SLAVES exceeds the block-code space");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("RST_PULSE_CYCLES must be at least 1");
  end

  lb_fabric_fsm_t    state_q;
  logic              op_wr_q;
  logic [SEL_W-1:0]  sel_q;

  logic                  req;
  logic [CODE_W-1:0]     req_code;
  logic [SLV_ADDR_W-1:0] req_local;
  logic                  req_mapped;
  logic [SEL_W-1:0]      req_sel;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  rst_wr;
  logic [NUM_SLAVES-1:0] rst_hit;
  logic                  sel_valid;
  logic [DATA_W-1:0]     sel_data;
  logic                  timeout;

  assign req        = lb.rd_en | lb.wr_en;
  assign req_code   = lb.addr[ADDR_W-1:SLV_ADDR_W];
  assign req_local  = lb.addr[SLV_ADDR_W-1:0];
  assign req_mapped = (32'(req_code) < NUM_SLAVES);
  assign req_sel    = SEL_W'(req_code);
  assign req_onehot = NUM_SLAVES'(1) << req_sel;
  // Soft-reset writes are consumed by the fabric and never reach the slave.
  assign rst_wr     = (state_q == IDLE) && lb.wr_en && req_mapped && (req_local == SLV_RST_ADDR);
  assign rst_hit    = rst_wr ? req_onehot : '0;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_valid = op_wr_q ? slv_wr_valid[i] : slv_rd_valid[i];
        sel_data  = slv_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef LB_FABRIC_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES);

  logic [WCNT_W-1:0] wait_cnt_q;

  // Counts completed WAIT cycles; reads 0 in the first WAIT cycle.
  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      wait_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
    end
  end

  assign timeout = (state_q == WAIT) && !sel_valid &&
                   (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      sel_q       <= '0;
      slv_rd_en   <= '0;
      slv_wr_en   <= '0;
      slv_addr    <= '0;
      slv_wr_data <= '0;
      lb.rd_valid <= 1'b0;
      lb.wr_valid <= 1'b0;
      lb.err      <= 1'b0;
      lb.rd_data  <= '0;
      err_cnt     <= '0;
    end else begin
      slv_rd_en   <= '0;
      slv_wr_en   <= '0;
      lb.rd_valid <= 1'b0;
      lb.wr_valid <= 1'b0;
      lb.err      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q     <= lb.wr_en;
            sel_q       <= req_sel;
            slv_addr    <= req_local;
            slv_wr_data <= lb.wr_data;
            if (!req_mapped) begin
              lb.rd_valid <= !lb.wr_en;
              lb.wr_valid <= lb.wr_en;
              lb.err      <= 1'b1;
              lb.rd_data  <= DATA_W'(LB_ERR_RDATA);
              err_cnt     <= sat_inc8(err_cnt);
            end else if (rst_wr) begin
              lb.wr_valid <= 1'b1;
            end else begin
              if (lb.wr_en) slv_wr_en <= req_onehot;
              else          slv_rd_en <= req_onehot;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sel_valid || timeout) begin
            state_q     <= IDLE;
            lb.rd_valid <= !op_wr_q;
            lb.wr_valid <= op_wr_q;
            lb.err      <= timeout;
            if (timeout) begin
              lb.rd_data <= DATA_W'(LB_ERR_RDATA);
              err_cnt    <= sat_inc8(err_cnt);
            end else if (!op_wr_q) begin
              lb.rd_data <= sel_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rst
    syn_lb_rst_stretch #(
      .PULSE_CYCLES (RST_PULSE_CYCLES)
    ) u_rst_stretch (
      .clk   (clk_ir),
      .rst   (rst_ir),
      .trig  (rst_hit[g]),
      .pulse (slv_rst[g])
    );
  end
endmodule
